// File: rtl/dragonfang_pkg.sv
// ---------------------------------------------------------------------------
// dragonfang_pkg
// Shared types and constants for the dragonfang vector pipeline.
//   TAG_LENGTH      width of a write-back destination tag
//   DATA_LENGTH     width of a write-back data word
//   NUM_WB_SOURCES  default number of functional units competing for write-back
//   data_packet_t   tag + data pair carried from a functional unit to register read
//   wrap_increment  next index of a circular search, wrapping at the modulus
// ---------------------------------------------------------------------------
package dragonfang_pkg;

   localparam int TAG_LENGTH     = 6;
   localparam int DATA_LENGTH    = 64;
   localparam int NUM_WB_SOURCES = 4;

   typedef struct packed {
      logic [TAG_LENGTH-1:0]  tag;
      logic [DATA_LENGTH-1:0] data;
   } data_packet_t;

   function automatic int wrap_increment(input int index, input int modulus);
      return (index + 1 >= modulus) ? 0 : index + 1;
   endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// ---------------------------------------------------------------------------
// round_robin_arbiter
// Purely combinational rotating-priority picker. The search begins at
// 'pointer' and wraps around; the first asserted request wins.
// Ports:
//   request      [WIDTH]    request vector
//   pointer      [INDEX_W]  index given highest priority this cycle
//   grant        [WIDTH]    one-hot grant (all zero when nothing requests)
//   grant_index  [INDEX_W]  binary index of the granted requester
// ---------------------------------------------------------------------------
module round_robin_arbiter #(
   parameter int WIDTH   = 4,
   parameter int INDEX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0]   request,
   input  logic [INDEX_W-1:0] pointer,
   output logic [WIDTH-1:0]   grant,
   output logic [INDEX_W-1:0] grant_index
);

   logic found;
   int   candidate;

   always_comb begin
      grant       = '0;
      grant_index = '0;
      found       = 1'b0;
      candidate   = 0;
      for (int offset = 0; offset < WIDTH; offset++) begin
         // Modulo keeps the search legal even for non-power-of-two widths.
         candidate = (int'(pointer) + offset) % WIDTH;
         if (!found && request[candidate]) begin
            found            = 1'b1;
            grant[candidate] = 1'b1;
            grant_index      = INDEX_W'(candidate);
         end
      end
   end

endmodule

// File: rtl/vector_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// vector_writeback_arbiter
// Picks one functional-unit write-back per cycle, round-robin, and holds it
// in a single output register slot feeding vector_register_read.
// Ports:
//   clock               sole clock, rising edge
//   reset_n             synchronous active-low reset
//   flush               synchronous pipeline flush; empties the slot, blocks grants
//   wb_stall            downstream cannot take the slot this cycle
//   source_valid  [N]   per-source write-back request
//   source_packet [N]   per-source tag and data (held stable until granted)
//   source_ready  [N]   per-source grant, combinational
//   write_back_request  registered slot-valid toward vector_register_read
//   write_back_packet   registered slot contents toward vector_register_read
// write_back_request / write_back_packet connect directly to the same-named
// inputs of vector_register_read.
// ---------------------------------------------------------------------------
module vector_writeback_arbiter
   import dragonfang_pkg::*;
#(
   parameter int NUM_SOURCES = NUM_WB_SOURCES
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   flush,
   input  logic                   wb_stall,
   input  logic [NUM_SOURCES-1:0] source_valid,
   input  data_packet_t           source_packet [NUM_SOURCES],
   output logic [NUM_SOURCES-1:0] source_ready,
   output logic                   write_back_request,
   output data_packet_t           write_back_packet
);

   localparam int INDEX_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

   logic [INDEX_W-1:0]     priority_pointer;
   logic [INDEX_W-1:0]     grant_index;
   logic [INDEX_W-1:0]     next_pointer;
   logic [NUM_SOURCES-1:0] arbiter_grant;
   logic                   slot_open;
   logic                   grant_enable;
   logic                   grant_fire;

   round_robin_arbiter #(
      .WIDTH   (NUM_SOURCES),
      .INDEX_W (INDEX_W)
   ) u_round_robin_arbiter (
      .request     (source_valid),
      .pointer     (priority_pointer),
      .grant       (arbiter_grant),
      .grant_index (grant_index)
   );

   // The slot can take a new entry when empty, or when its current entry
   // leaves this same edge; that gives back-to-back refill with no bubble.
   assign slot_open    = !write_back_request || !wb_stall;
   assign grant_enable = reset_n && !flush && slot_open;
   assign source_ready = grant_enable ? arbiter_grant : '0;
   assign grant_fire   = |source_ready;
   assign next_pointer = INDEX_W'(wrap_increment(int'(grant_index), NUM_SOURCES));

   // Output slot and priority pointer. Flush empties the slot but leaves the
   // stale packet in place; it is never visible with write_back_request low.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         write_back_request <= 1'b0;
         write_back_packet  <= '0;
         priority_pointer   <= '0;
      end else if (flush) begin
         write_back_request <= 1'b0;
      end else if (grant_fire) begin
         write_back_request <= 1'b1;
         write_back_packet  <= source_packet[grant_index];
         priority_pointer   <= next_pointer;
      end else if (slot_open) begin
         write_back_request <= 1'b0;
      end
   end

endmodule
